// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters for fetch-side branch prediction.
// Optional statistics counters are enabled by defining BP_STATS_EN.
module branch_predictor #(
    parameter int unsigned PC_W  = 16,
    parameter int unsigned IDX_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fetch_vld,
    input  logic [PC_W-1:0] fetch_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_target,
    input  logic            upd_vld,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target,
`ifdef BP_STATS_EN
    input  logic            upd_mispred,
    output logic [15:0]     stat_lookups,
    output logic [15:0]     stat_hits,
    output logic [15:0]     stat_mispred
`else
    input  logic            upd_mispred
`endif
);

    localparam int Entries = 2 ** IDX_W;
    localparam int TagW    = PC_W - IDX_W;

    logic [Entries-1:0] valid_q;
    logic [TagW-1:0]    tag_q    [Entries];
    logic [PC_W-1:0]    target_q [Entries];
    logic [1:0]         ctr_q    [Entries];

    logic [IDX_W-1:0] fetch_idx;
    logic [TagW-1:0]  fetch_tag;
    logic [PC_W-1:0]  fetch_pc_inc;

    assign fetch_idx    = fetch_pc[IDX_W-1:0];
    assign fetch_tag    = fetch_pc[PC_W-1:IDX_W];
    assign fetch_pc_inc = fetch_pc + PC_W'(1);

    // Lookup reads registered state only; reset forces a miss in the same cycle.
    always_comb begin
        pred_hit    = rst_n & fetch_vld & valid_q[fetch_idx] & (tag_q[fetch_idx] == fetch_tag);
        pred_taken  = pred_hit & ctr_q[fetch_idx][1];
        pred_target = pred_taken ? target_q[fetch_idx] : fetch_pc_inc;
    end

    logic [IDX_W-1:0] upd_idx;
    logic [TagW-1:0]  upd_tag;
    logic             upd_hit;
    logic [1:0]       upd_ctr_cur;
    logic [1:0]       upd_ctr_d;
    logic             upd_alloc;
    logic             upd_tgt_we;

    assign upd_idx     = upd_pc[IDX_W-1:0];
    assign upd_tag     = upd_pc[PC_W-1:IDX_W];
    assign upd_hit     = valid_q[upd_idx] & (tag_q[upd_idx] == upd_tag);
    assign upd_ctr_cur = ctr_q[upd_idx];

    always_comb begin
        upd_ctr_d  = upd_ctr_cur;
        upd_alloc  = 1'b0;
        upd_tgt_we = 1'b0;
        if (upd_vld) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    upd_ctr_d  = (upd_ctr_cur == 2'b11) ? 2'b11 : upd_ctr_cur + 2'd1;
                    upd_tgt_we = 1'b1;
                end else begin
                    upd_ctr_d = (upd_ctr_cur == 2'b00) ? 2'b00 : upd_ctr_cur - 2'd1;
                end
            end else if (upd_taken) begin
                // Never-taken branches stay out of the table; taken misses evict.
                upd_alloc  = 1'b1;
                upd_tgt_we = 1'b1;
                upd_ctr_d  = 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < Entries; i++) begin
                ctr_q[i] <= 2'b01;
            end
        end else if (upd_vld) begin
            ctr_q[upd_idx] <= upd_ctr_d;
            if (upd_alloc) begin
                valid_q[upd_idx] <= 1'b1;
            end
        end
    end

    // Tag and target carry no reset; valid_q masks their contents.
    always_ff @(posedge clk) begin
        if (rst_n && upd_tgt_we) begin
            target_q[upd_idx] <= upd_target;
        end
        if (rst_n && upd_alloc) begin
            tag_q[upd_idx] <= upd_tag;
        end
    end

`ifdef BP_STATS_EN
    logic [15:0] stat_lookups_q;
    logic [15:0] stat_hits_q;
    logic [15:0] stat_mispred_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_lookups_q <= '0;
            stat_hits_q    <= '0;
            stat_mispred_q <= '0;
        end else begin
            if (fetch_vld && stat_lookups_q != 16'hFFFF) begin
                stat_lookups_q <= stat_lookups_q + 16'd1;
            end
            if (pred_hit && stat_hits_q != 16'hFFFF) begin
                stat_hits_q <= stat_hits_q + 16'd1;
            end
            if (upd_vld && upd_mispred && stat_mispred_q != 16'hFFFF) begin
                stat_mispred_q <= stat_mispred_q + 16'd1;
            end
        end
    end

    assign stat_lookups = stat_lookups_q;
    assign stat_hits    = stat_hits_q;
    assign stat_mispred = stat_mispred_q;
`else
    logic unused_mispred;
    assign unused_mispred = upd_mispred;
`endif

endmodule
